// File: rtl/l2_line_responder.sv
// l2_line_responder: fixed-latency backing store that serves one 128-bit line
// at a time to an L2 cache over a strobe-and-response handshake.
//
// Ports:
//   clk, reset_n      clock (rising edge) and asynchronous active-low reset
//   pmem_address      byte address of the requested line; bits [3:0] ignored
//   pmem_read/write   request strobes, held by the requester until pmem_resp
//   pmem_wdata        line to write (sampled when the request is accepted)
//   pmem_rdata        line returned by the most recent completed read
//   pmem_resp         one-cycle completion pulse
//   proto_err         sticky flag: read and write were requested together
//   rd_count/wr_count saturating counts of completed reads / writes
module l2_line_responder #(
  parameter int LATENCY    = 4,
  parameter int INDEX_BITS = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [15:0]  pmem_address,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         proto_err,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
);

  localparam int         LINES  = 2**INDEX_BITS;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Request captured at acceptance; later input changes are ignored.
  typedef struct packed {
    logic                  is_rd;
    logic [INDEX_BITS-1:0] idx;
    logic [127:0]          wdata;
  } req_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  req_t                  req;
  logic                  accept, both_err, load_rdata, strobe_held;
  logic [INDEX_BITS-1:0] rd_idx;
  logic [127:0]          mem [LINES];

  // Only the index slice of the address is meaningful.
  logic unused_addr;
  assign unused_addr = ^pmem_address;

  assign strobe_held = req.is_rd ? pmem_read : pmem_write;
  assign pmem_resp   = (state == RESP);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    both_err   = 1'b0;
    load_rdata = 1'b0;
    rd_idx     = req.idx;
    unique case (state)
      IDLE: begin
        if (pmem_read ^ pmem_write) begin
          accept  = 1'b1;
          cnt_nxt = LAT_M1;
          rd_idx  = pmem_address[4 +: INDEX_BITS];
          if (LATENCY == 1) begin
            state_nxt  = RESP;
            load_rdata = pmem_read;
          end else begin
            state_nxt = BUSY;
          end
        end else if (pmem_read && pmem_write) begin
          both_err = 1'b1;
        end
      end
      BUSY: begin
        // Abort wins over completion if the strobe drops on the last cycle.
        if (!strobe_held) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 4'd1;
          if (cnt <= 4'd1) begin
            state_nxt  = RESP;
            // Read data is registered on the way into RESP so it is valid
            // in the same cycle as pmem_resp.
            load_rdata = req.is_rd;
          end
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      req        <= '0;
      pmem_rdata <= '0;
      proto_err  <= 1'b0;
      rd_count   <= '0;
      wr_count   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept)
        req <= {pmem_read, pmem_address[4 +: INDEX_BITS], pmem_wdata};
      if (both_err)
        proto_err <= 1'b1;
      if (load_rdata)
        pmem_rdata <= mem[rd_idx];
      if (state == RESP) begin
        if (req.is_rd) begin
          if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
        end else begin
          if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end
      end
    end
  end

  // Line store: no reset. A write lands only at the RESP edge, so an aborted
  // or reset-interrupted write never reaches RESP and never updates it.
  always_ff @(posedge clk) begin
    if (state == RESP && !req.is_rd)
      mem[req.idx] <= req.wdata;
  end

endmodule
